ntt_bfu_pipe: RTL and testbench

// Pipelined modular butterfly unit sitting directly downstream of the NTT address

---
 rtl/ntt_bfu_pipe.sv | 127 ++++++++++++
 tb/tb_ntt_bfu_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfu_pipe.sv
// Pipelined modular butterfly (CT forward / GS inverse) for the NTT datapath.
// Register ranks: S1 operands, S2 product, S3 Barrett remainder, S4 reduced
// twiddle product, then the output register (x/y). An op accepted at edge N
// therefore drives out_valid after edge N+4.
module ntt_bfu_pipe #(
  parameter int unsigned DW = 14,
  parameter int unsigned Q  = 12289
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_mode,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_w,
  output logic          out_valid,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic          busy,
  output logic          err
);

  localparam int unsigned     PW     = 2 * DW;
  localparam longint unsigned MU_VAL = (64'd1 << PW) / Q;
  localparam logic [2*PW:0]   MU     = (2*PW+1)'(MU_VAL);
  localparam logic [PW:0]     QQ     = (PW+1)'(Q);
  localparam logic [DW:0]     QE     = (DW+1)'(Q);

  function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QE) s = s - QE;
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + QE;
    return d[DW-1:0];
  endfunction

  // stage registers
  logic          v1, v2, v3, v4;
  logic          m1, m2, m3, m4;
  logic [DW-1:0] a1, b1, w1, a2, a3, a4;
  logic [PW-1:0] p2;
  logic [DW:0]   r3;
  logic [DW-1:0] t4;

  // combinational stage logic
  logic [DW-1:0] s2_s, s2_m;
  logic [PW:0]   qhat;
  logic [DW:0]   r_raw;
  logic [DW-1:0] t_red;
  logic [DW-1:0] x_next, y_next;
  logic          bad_in;

  // S2 butterfly pre-processing: GS folds the add/sub in before the multiply
  always_comb begin
    s2_s = add_mod(a1, b1);
    s2_m = m1 ? sub_mod(a1, b1) : b1;
  end

  // Barrett: quotient estimate is at most one short, so r_raw lies in [0, 2Q);
  // only the low DW+1 bits of p - qhat*Q are needed for the remainder
  always_comb begin
    qhat  = (PW+1)'(((2*PW+1)'(p2) * MU) >> PW);
    r_raw = (DW+1)'((PW+1)'(p2) - qhat * QQ);
  end

  // S4 conditional subtract and final butterfly combination
  always_comb begin
    t_red  = (r3 >= QE) ? DW'(r3 - QE) : r3[DW-1:0];
    x_next = m4 ? a4 : add_mod(a4, t4);
    y_next = m4 ? t4 : sub_mod(a4, t4);
  end

  // range check on accepted operands
  always_comb begin
    bad_in = in_valid && (({1'b0, in_a} >= QE) || ({1'b0, in_b} >= QE) || ({1'b0, in_w} >= QE));
  end

  // pipeline valid/mode/data registers, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0; m4 <= 1'b0;
      a1 <= '0; b1 <= '0; w1 <= '0;
      a2 <= '0; p2 <= '0;
      a3 <= '0; r3 <= '0;
      a4 <= '0; t4 <= '0;
    end else begin
      v1 <= in_valid; m1 <= in_mode;
      a1 <= in_a; b1 <= in_b; w1 <= in_w;
      v2 <= v1; m2 <= m1;
      a2 <= m1 ? s2_s : a1;
      p2 <= PW'(s2_m) * PW'(w1);
      v3 <= v2; m3 <= m2; a3 <= a2; r3 <= r_raw;
      v4 <= v3; m4 <= m3; a4 <= a3; t4 <= t_red;
    end
  end

  // output register: results hold while no valid op leaves S4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= v4;
      if (v4) begin
        out_x <= x_next;
        out_y <= y_next;
      end
    end
  end

  // sticky out-of-range flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (bad_in) err <= 1'b1;
  end

  assign busy = v1 | v2 | v3 | v4;

endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// Directed bench for ntt_bfu_pipe: inputs driven and outputs sampled on the
// falling edge; expected values come from a direct modular-arithmetic model.
module tb_ntt_bfu_pipe;
  localparam int DW = 14;
  localparam int Q  = 12289;
  localparam int N  = 130;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0, in_w = '0;
  logic          out_valid, busy, err;
  logic [DW-1:0] out_x, out_y;

  int total = 0;
  int bad = 0;
  int last_x = 0;
  int last_y = 0;

  bit hv [N];
  int hx [N];
  int hy [N];

  ntt_bfu_pipe #(.DW(DW), .Q(Q)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit md, input int a, input int b, input int w);
    in_valid = v;
    in_mode  = md;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_w     = DW'(w);
  endtask

  function automatic void model(input int a, input int b, input int w, input bit md,
                                output int x, output int y);
    longint t, s, m;
    if (!md) begin
      t = (longint'(b) * w) % Q;
      x = int'((a + t) % Q);
      y = int'((a - t + Q) % Q);
    end else begin
      s = (a + b) % Q;
      m = (a - b + Q) % Q;
      t = (m * w) % Q;
      x = int'(s);
      y = int'(t);
    end
  endfunction

  // single op from a falling edge; leaves the bench on a falling edge with an empty pipe
  task automatic run_one(input string tag, input bit md, input int a, input int b, input int w,
                         input int ex, input int ey);
    drive(1'b1, md, a, b, w);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "_vld_early"}, 32'(out_valid), 32'd0);
    tick(); tick(); tick();
    chk({tag, "_busy_s4"}, 32'(busy), 32'd1);
    chk({tag, "_vld_lat3"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_x"}, 32'(out_x), 32'(ex));
    chk({tag, "_y"}, 32'(out_y), 32'(ey));
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    last_x = ex;
    last_y = ey;
    tick();
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_x_hold"}, 32'(out_x), 32'(ex));
    chk({tag, "_y_hold"}, 32'(out_y), 32'(ey));
  endtask

  initial begin
    int k;
    int ex, ey;
    int a, b, w;
    bit md;

    // reset state
    tick(); tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(out_x), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // directed butterflies
    run_one("ct_basic", 1'b0, 5, 3, 2, 11, 12288);
    run_one("gs_basic", 1'b1, 5, 3, 2, 8, 4);
    run_one("ct_wrap", 1'b0, 12288, 12288, 12288, 0, 12287);
    run_one("gs_wrap", 1'b1, 12288, 12288, 12288, 12287, 0);

    // back-to-back stream with two bubbles, alternating modes
    k = 0;
    for (int c = 0; c < N + 5; c++) begin
      if (c >= 5) begin
        chk($sformatf("stream_vld[%0d]", c - 5), 32'(out_valid), 32'(hv[c-5]));
        if (hv[c-5]) begin
          chk($sformatf("stream_x[%0d]", c - 5), 32'(out_x), 32'(hx[c-5]));
          chk($sformatf("stream_y[%0d]", c - 5), 32'(out_y), 32'(hy[c-5]));
          last_x = hx[c-5];
          last_y = hy[c-5];
        end else begin
          chk($sformatf("stream_hold_x[%0d]", c - 5), 32'(out_x), 32'(last_x));
          chk($sformatf("stream_hold_y[%0d]", c - 5), 32'(out_y), 32'(last_y));
        end
      end else begin
        chk($sformatf("stream_fill_vld[%0d]", c), 32'(out_valid), 32'd0);
      end
      if (c < N) begin
        if (c == 40 || c == 91) begin
          hv[c] = 1'b0;
          drive(1'b0, 1'b0, 0, 0, 0);
        end else begin
          a  = int'($urandom_range(Q - 1, 0));
          b  = int'($urandom_range(Q - 1, 0));
          w  = int'($urandom_range(Q - 1, 0));
          md = k[0];
          k++;
          model(a, b, w, md, ex, ey);
          hv[c] = 1'b1;
          hx[c] = ex;
          hy[c] = ey;
          drive(1'b1, md, a, b, w);
        end
      end else begin
        drive(1'b0, 1'b0, 0, 0, 0);
      end
      tick();
    end
    chk("stream_drained_busy", 32'(busy), 32'd0);

    // reset with three ops in flight
    drive(1'b1, 1'b0, 1, 2, 3); tick();
    drive(1'b1, 1'b1, 4, 5, 6); tick();
    drive(1'b1, 1'b0, 7, 8, 9); tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    chk("flush_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("flush_busy_async", 32'(busy), 32'd0);
    chk("flush_vld_async", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_err", 32'(err), 32'd0);
    chk("flush_x", 32'(out_x), 32'd0);
    last_x = 0;
    last_y = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("flush_vld[%0d]", i), 32'(out_valid), 32'd0);
      chk($sformatf("flush_busy[%0d]", i), 32'(busy), 32'd0);
    end

    // err: ignored without in_valid, sticky once set
    drive(1'b0, 1'b0, 12289, 0, 0); tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    chk("err_no_valid", 32'(err), 32'd0);
    tick();
    chk("err_no_valid_late", 32'(err), 32'd0);
    drive(1'b1, 1'b0, 12289, 0, 0); tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    chk("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    run_one("err_good_op", 1'b1, 5, 3, 2, 8, 4);
    chk("err_sticky", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
